// File: rtl/ram_loader_pkg.sv
// Shared constants for the program-RAM loader: RAM geometry, frame sync byte and FSM encoding.
package ram_loader_pkg;

    localparam int unsigned RAM_DEPTH   = 16;
    localparam int unsigned RAM_ADDR_W  = 4;
    localparam int unsigned RAM_DATA_W  = 8;
    localparam logic [7:0]  SYNC_BYTE   = 8'hA5;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t LOAD  = 3'd1;
    localparam state_t WRITE = 3'd2;
    localparam state_t READ  = 3'd3;
    localparam state_t CMP   = 3'd4;
    localparam state_t CSUM  = 3'd5;
    localparam state_t DONE  = 3'd6;
    localparam state_t ERR   = 3'd7;

endpackage

// File: rtl/loader_csum.sv
// Running modulo-2**DATA_W byte sum for the loader, with synchronous clear and a compare output.
module loader_csum #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              clear,
    input  logic              add_en,
    input  logic [DATA_W-1:0] add_data,
    input  logic [DATA_W-1:0] cmp_data,
    output logic              match
);

    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sum_q <= '0;
        end else if (clear) begin
            sum_q <= '0;
        end else if (add_en) begin
            sum_q <= sum_q + add_data;
        end
    end

    assign match = (sum_q == cmp_data);

endmodule

// File: rtl/ram_loader.sv
// Loads a SYNC-framed, checksummed byte stream into the program RAM while holding the CPU.
// Optional RAM_LOADER_READBACK_EN adds a read-back verify of every written word.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int unsigned DEPTH  = RAM_DEPTH,
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W,
    parameter logic [DATA_W-1:0] SYNC = DATA_W'(SYNC_BYTE)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              accept;
    logic              last;
    logic              csum_clear, csum_add, csum_match;

    assign in_ready = (state_q == IDLE) || (state_q == LOAD) ||
                      (state_q == CSUM) || (state_q == ERR);
    assign accept   = in_valid && in_ready;
    assign last     = (addr_q == ADDR_W'(DEPTH - 1));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        csum_clear = 1'b0;
        csum_add   = 1'b0;
        case (state_q)
            IDLE, ERR: begin
                if (accept && in_data == SYNC) begin
                    state_d    = LOAD;
                    addr_d     = '0;
                    csum_clear = 1'b1;
                end
            end
            LOAD: begin
                if (accept) begin
                    data_d   = in_data;
                    csum_add = 1'b1;
                    state_d  = WRITE;
                end
            end
`ifdef RAM_LOADER_READBACK_EN
            WRITE: state_d = READ;
            READ:  state_d = CMP;
            CMP: begin
                if (ram_rdata != data_q) begin
                    state_d = ERR;
                end else if (last) begin
                    state_d = CSUM;
                end else begin
                    state_d = LOAD;
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
`else
            WRITE: begin
                if (last) begin
                    state_d = CSUM;
                end else begin
                    state_d = LOAD;
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
`endif
            CSUM: begin
                if (accept) begin
                    state_d = csum_match ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    loader_csum #(
        .DATA_W (DATA_W)
    ) u_csum (
        .clk      (clk),
        .clr      (clr),
        .clear    (csum_clear),
        .add_en   (csum_add),
        .add_data (in_data),
        .cmp_data (in_data),
        .match    (csum_match)
    );

    assign ram_addr  = addr_q;
    assign ram_wdata = data_q;
    assign ram_we    = (state_q == WRITE);
    assign done      = (state_q == DONE);
    assign err       = (state_q == ERR);
    // ERR keeps the CPU held so a bad image never runs.
    assign cpu_hold  = (state_q != IDLE) && (state_q != DONE);
    assign busy      = cpu_hold && (state_q != ERR);

`ifdef RAM_LOADER_READBACK_EN
    assign ram_re = (state_q == READ);
`else
    logic unused_rdata;
    assign unused_rdata = ^ram_rdata;
    assign ram_re       = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: directed frames plus random frames against a frame-level model.
module tb_ram_loader;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_we;
    logic       ram_re;
    logic [7:0] ram_rdata;
    logic       cpu_hold, busy, done, err;

    int passes = 0;
    int total  = 0;

    logic [7:0]  fd [16];
    logic [7:0]  mem [16];
    logic        corrupt_en = 1'b0;
    logic [11:0] wq [$];
    int          done_cnt = 0;

    always #5 clk = ~clk;

    ram_loader dut (
        .clk       (clk),
        .clr       (clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_rdata (ram_rdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Bench RAM; optionally corrupts address 7 on readback.
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wq.push_back({ram_addr, ram_wdata});
        end
        if (ram_re) ram_rdata <= mem[ram_addr] ^ ((corrupt_en && ram_addr == 4'd7) ? 8'hFF : 8'h00);
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("handshake_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    function automatic logic [7:0] ref_sum();
        int s = 0;
        for (int i = 0; i < 16; i++) s = (s + int'(fd[i])) % 256;
        return 8'(s);
    endfunction

    // corrupt: address whose readback fails (-1 = none); stall_after: data bytes before a stall (0 = none)
    task automatic run_frame(input string tag, input logic [7:0] ck, input int stall_after,
                             input int corrupt);
        int  w0 = wq.size();
        int  d0 = done_cnt;
        int  nw = (corrupt >= 0) ? corrupt + 1 : 16;
        logic good = (corrupt < 0) && (ck == ref_sum());
        int  bad = 0;
        send(8'hA5);
        for (int i = 0; i < 16; i++) begin
            send(fd[i]);
            if (i == 0) begin
                chk({tag, "_we_latency"}, 32'(ram_we), 32'd1);
                chk({tag, "_first_addr"}, 32'(ram_addr), 32'd0);
            end
            if (stall_after != 0 && i + 1 == stall_after) begin
                repeat (50) @(negedge clk);
                chk({tag, "_stall_writes"}, 32'(wq.size() - w0), 32'(stall_after));
                chk({tag, "_stall_busy"}, 32'(busy), 32'd1);
            end
        end
        send(ck);
        chk({tag, "_done_pulse"}, 32'(done), 32'(good));
        repeat (4) @(negedge clk);
        chk({tag, "_nwrites"}, 32'(wq.size() - w0), 32'(nw));
        for (int i = 0; i < nw && w0 + i < wq.size(); i++)
            if (wq[w0 + i] !== {4'(i), fd[i]}) bad++;
        chk({tag, "_write_seq"}, 32'(bad), 32'd0);
        chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'(good));
        chk({tag, "_err"}, 32'(err), 32'(!good));
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!good));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        chk({tag, "_ram_re"}, 32'(ram_re), 32'd0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        logic [7:0] g;
        logic [7:0] ck;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        ram_rdata = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        clr = 1'b1;

        for (int i = 0; i < 16; i++) fd[i] = 8'(i);
        run_frame("good", 8'h78, 0, -1);

        for (int i = 0; i < 16; i++) fd[i] = 8'h01;
        run_frame("badck", 8'h11, 0, -1);
        for (int i = 0; i < 16; i++) fd[i] = 8'(i);
        run_frame("recover", 8'h78, 0, -1);

        send(8'h00);
        send(8'hFF);
        send(8'h3C);
        chk("garbage_busy", 32'(busy), 32'd0);
        run_frame("garbage", 8'h78, 0, -1);

        run_frame("stall", 8'h78, 5, -1);

        send(8'hA5);
        for (int i = 0; i < 8; i++) send(fd[i]);
        clr = 1'b0;
        #1 chk_reset("midreset");
        @(negedge clk);
        clr = 1'b1;
        run_frame("after_reset", 8'h78, 0, -1);

        for (int r = 0; r < 4; r++) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h00;
            send(g);
            for (int i = 0; i < 16; i++) fd[i] = 8'($urandom_range(0, 255));
            ck = ref_sum();
            if (r % 2 == 1) ck = ck ^ 8'($urandom_range(1, 255));
            run_frame($sformatf("rand%0d", r), ck, 0, -1);
        end

`ifdef RAM_LOADER_READBACK_EN
        for (int i = 0; i < 16; i++) fd[i] = 8'(i);
        corrupt_en = 1'b1;
        run_frame("readback_bad", 8'h78, 0, 7);
        corrupt_en = 1'b0;
        run_frame("readback_good", 8'h78, 0, -1);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
